// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: shared AXI response codes, arbiter states and owner encoding
package mem_arbiter_pkg;
  localparam logic [1:0] RESP_OKAY = 2'b00;
  typedef enum logic [2:0] {ST_IDLE, ST_RD_ADDR, ST_RD_DATA, ST_WR_REQ, ST_WR_RESP} state_e;
  typedef enum logic {OWNER_IF = 1'b0, OWNER_MEM = 1'b1} owner_e;
  function automatic logic resp_err(input logic [1:0] resp);
    return resp != RESP_OKAY;
  endfunction
endpackage

// File: rtl/mem_arb_grant.sv
// mem_arb_grant: combinational grant select (fixed mem priority, or round-robin under MEM_ARB_RR_EN)
module mem_arb_grant
  import mem_arbiter_pkg::*;
(
  input  logic   if_req_i,
  input  logic   mem_req_i,
  input  logic   block_i,
  input  owner_e last_i,
  output logic   gnt_if_o,
  output logic   gnt_mem_o
);
  logic mem_first;
`ifdef MEM_ARB_RR_EN
  assign mem_first = last_i == OWNER_IF;
`else
  logic unused_last;
  assign unused_last = last_i == OWNER_IF;
  assign mem_first = 1'b1;
`endif
  assign gnt_mem_o = ~block_i & mem_req_i & (mem_first | ~if_req_i);
  assign gnt_if_o  = ~block_i & if_req_i & (~mem_first | ~mem_req_i);
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one AXI-Lite master between fetch and data requesters; MEM_ARB_RR_EN selects round-robin
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                if_req_i,
  input  logic [ADDR_W-1:0]   if_addr_i,
  output logic [DATA_W-1:0]   if_rdata_o,
  output logic                if_done_o,
  output logic                if_stall_req_o,
  input  logic                mem_req_i,
  input  logic                mem_we_i,
  input  logic [DATA_W/8-1:0] mem_sel_i,
  input  logic [ADDR_W-1:0]   mem_addr_i,
  input  logic [DATA_W-1:0]   mem_wdata_i,
  output logic [DATA_W-1:0]   mem_rdata_o,
  output logic                mem_done_o,
  output logic                mem_stall_req_o,
  output logic                err_o,
  output logic [ADDR_W-1:0]   m_araddr,
  output logic                m_arvalid,
  input  logic                m_arready,
  input  logic [DATA_W-1:0]   m_rdata,
  input  logic [1:0]          m_rresp,
  input  logic                m_rvalid,
  output logic                m_rready,
  output logic [ADDR_W-1:0]   m_awaddr,
  output logic                m_awvalid,
  input  logic                m_awready,
  output logic [DATA_W-1:0]   m_wdata,
  output logic [DATA_W/8-1:0] m_wstrb,
  output logic                m_wvalid,
  input  logic                m_wready,
  input  logic [1:0]          m_bresp,
  input  logic                m_bvalid,
  output logic                m_bready
);
  state_e state_q, state_d;
  owner_e owner_q, owner_d, last_q, last_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d, if_rdata_q, if_rdata_d, mem_rdata_q, mem_rdata_d;
  logic [DATA_W/8-1:0] sel_q, sel_d;
  logic aw_done_q, aw_done_d, w_done_q, w_done_d;
  logic if_done_q, if_done_d, mem_done_q, mem_done_d, err_q, err_d;
  logic arvalid_q, arvalid_d, rready_q, rready_d, awvalid_q, awvalid_d;
  logic wvalid_q, wvalid_d, bready_q, bready_d;
  logic gnt_if, gnt_mem;

  mem_arb_grant u_grant (
    .if_req_i  (if_req_i),
    .mem_req_i (mem_req_i),
    .block_i   (if_done_q | mem_done_q),
    .last_i    (last_q),
    .gnt_if_o  (gnt_if),
    .gnt_mem_o (gnt_mem)
  );

  // Next-state and registered-output logic; AXI valids/readies derive from the next state
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    last_d      = last_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    sel_d       = sel_q;
    aw_done_d   = aw_done_q;
    w_done_d    = w_done_q;
    if_rdata_d  = if_rdata_q;
    mem_rdata_d = mem_rdata_q;
    if_done_d   = 1'b0;
    mem_done_d  = 1'b0;
    err_d       = 1'b0;
    case (state_q)
      ST_IDLE: if (gnt_if | gnt_mem) begin
        owner_d   = gnt_mem ? OWNER_MEM : OWNER_IF;
        last_d    = gnt_mem ? OWNER_MEM : OWNER_IF;
        addr_d    = gnt_mem ? mem_addr_i : if_addr_i;
        wdata_d   = mem_wdata_i;
        sel_d     = gnt_mem ? mem_sel_i : '0;
        aw_done_d = 1'b0;
        w_done_d  = 1'b0;
        state_d   = (gnt_mem & mem_we_i) ? ST_WR_REQ : ST_RD_ADDR;
      end
      ST_RD_ADDR: if (m_arready) state_d = ST_RD_DATA;
      ST_RD_DATA: if (m_rvalid) begin
        state_d     = ST_IDLE;
        err_d       = resp_err(m_rresp);
        if_done_d   = owner_q == OWNER_IF;
        mem_done_d  = owner_q == OWNER_MEM;
        if_rdata_d  = owner_q == OWNER_IF ? m_rdata : if_rdata_q;
        mem_rdata_d = owner_q == OWNER_MEM ? m_rdata : mem_rdata_q;
      end
      ST_WR_REQ: begin
        aw_done_d = aw_done_q | (awvalid_q & m_awready);
        w_done_d  = w_done_q | (wvalid_q & m_wready);
        if (aw_done_d & w_done_d) state_d = ST_WR_RESP;
      end
      ST_WR_RESP: if (m_bvalid) begin
        state_d    = ST_IDLE;
        err_d      = resp_err(m_bresp);
        mem_done_d = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
    arvalid_d = state_d == ST_RD_ADDR;
    rready_d  = state_d == ST_RD_DATA;
    awvalid_d = (state_d == ST_WR_REQ) & ~aw_done_d;
    wvalid_d  = (state_d == ST_WR_REQ) & ~w_done_d;
    bready_d  = state_d == ST_WR_RESP;
  end

  // State and output registers; reset aborts any transaction immediately
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      owner_q     <= OWNER_IF;
      last_q      <= OWNER_MEM;
      addr_q      <= '0;
      wdata_q     <= '0;
      sel_q       <= '0;
      aw_done_q   <= 1'b0;
      w_done_q    <= 1'b0;
      if_rdata_q  <= '0;
      mem_rdata_q <= '0;
      if_done_q   <= 1'b0;
      mem_done_q  <= 1'b0;
      err_q       <= 1'b0;
      arvalid_q   <= 1'b0;
      rready_q    <= 1'b0;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      bready_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      last_q      <= last_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      sel_q       <= sel_d;
      aw_done_q   <= aw_done_d;
      w_done_q    <= w_done_d;
      if_rdata_q  <= if_rdata_d;
      mem_rdata_q <= mem_rdata_d;
      if_done_q   <= if_done_d;
      mem_done_q  <= mem_done_d;
      err_q       <= err_d;
      arvalid_q   <= arvalid_d;
      rready_q    <= rready_d;
      awvalid_q   <= awvalid_d;
      wvalid_q    <= wvalid_d;
      bready_q    <= bready_d;
    end
  end

  assign if_rdata_o      = if_rdata_q;
  assign mem_rdata_o     = mem_rdata_q;
  assign if_done_o       = if_done_q;
  assign mem_done_o      = mem_done_q;
  assign err_o           = err_q;
  assign if_stall_req_o  = if_req_i & ~if_done_q;
  assign mem_stall_req_o = mem_req_i & ~mem_done_q;
  assign m_araddr        = addr_q;
  assign m_awaddr        = addr_q;
  assign m_wdata         = wdata_q;
  assign m_wstrb         = sel_q;
  assign m_arvalid       = arvalid_q;
  assign m_rready        = rready_q;
  assign m_awvalid       = awvalid_q;
  assign m_wvalid        = wvalid_q;
  assign m_bready        = bready_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed vector table plus arbitration and mid-transaction reset sequences
module tb_mem_arbiter;
  logic clk = 1'b0, rst = 1'b1;
  always #5 clk = ~clk;
  logic if_req = 0, mem_req = 0, mem_we = 0;
  logic [31:0] if_addr = 0, mem_addr = 0, mem_wdata = 0;
  logic [3:0] mem_sel = 0;
  logic [31:0] if_rdata_o, mem_rdata_o;
  logic if_done_o, mem_done_o, if_stall_req_o, mem_stall_req_o, err_o;
  logic [31:0] m_araddr, m_awaddr, m_wdata, m_rdata;
  logic [3:0] m_wstrb;
  logic [1:0] m_rresp, m_bresp;
  logic m_arvalid, m_arready, m_rvalid, m_rready, m_awvalid, m_awready;
  logic m_wvalid, m_wready, m_bvalid, m_bready;

  mem_arbiter dut (
    .clk(clk), .rst(rst),
    .if_req_i(if_req), .if_addr_i(if_addr), .if_rdata_o(if_rdata_o),
    .if_done_o(if_done_o), .if_stall_req_o(if_stall_req_o),
    .mem_req_i(mem_req), .mem_we_i(mem_we), .mem_sel_i(mem_sel),
    .mem_addr_i(mem_addr), .mem_wdata_i(mem_wdata), .mem_rdata_o(mem_rdata_o),
    .mem_done_o(mem_done_o), .mem_stall_req_o(mem_stall_req_o), .err_o(err_o),
    .m_araddr(m_araddr), .m_arvalid(m_arvalid), .m_arready(m_arready),
    .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rvalid(m_rvalid), .m_rready(m_rready),
    .m_awaddr(m_awaddr), .m_awvalid(m_awvalid), .m_awready(m_awready),
    .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wvalid(m_wvalid), .m_wready(m_wready),
    .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready)
  );

  typedef struct {
    logic is_mem, we;
    logic [31:0] addr, wdata, rdata;
    logic [3:0] sel;
    logic [1:0] resp;
    logic err;
    int ar_dly, r_dly, aw_dly, w_dly, lat;
  } vec_t;

  int checks = 0, fails = 0;
  int ar_dly = 0, r_dly = 0, aw_dly = 0, w_dly = 0;
  logic [31:0] slv_rdata = 0;
  logic [1:0] slv_resp = 0;
  logic [31:0] exp_if = 0, exp_mem = 0;
  int ar_hs = 0, aw_hs = 0, w_hs = 0, ifd_n = 0, memd_n = 0;
  logic [31:0] cap_araddr = 0, cap_awaddr = 0, cap_wdata = 0;
  logic [3:0] cap_wstrb = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Slave: each ready/valid rises after the configured number of wait cycles
  initial begin
    int ar_c = 0, r_c = 0, aw_c = 0, w_c = 0;
    m_arready = 0; m_rvalid = 0; m_awready = 0; m_wready = 0; m_bvalid = 0;
    m_rdata = 0; m_rresp = 0; m_bresp = 0;
    forever begin
      @(negedge clk);
      m_rdata = slv_rdata; m_rresp = slv_resp; m_bresp = slv_resp;
      if (m_arvalid) begin m_arready = ar_c >= ar_dly; ar_c++; end else begin m_arready = 0; ar_c = 0; end
      if (m_rready) begin m_rvalid = r_c >= r_dly; r_c++; end else begin m_rvalid = 0; r_c = 0; end
      if (m_awvalid) begin m_awready = aw_c >= aw_dly; aw_c++; end else begin m_awready = 0; aw_c = 0; end
      if (m_wvalid) begin m_wready = w_c >= w_dly; w_c++; end else begin m_wready = 0; w_c = 0; end
      m_bvalid = m_bready;
    end
  end

  always @(posedge clk) begin
    if (m_arvalid && m_arready) begin ar_hs <= ar_hs + 1; cap_araddr <= m_araddr; end
    if (m_awvalid && m_awready) begin aw_hs <= aw_hs + 1; cap_awaddr <= m_awaddr; end
    if (m_wvalid && m_wready) begin w_hs <= w_hs + 1; cap_wdata <= m_wdata; cap_wstrb <= m_wstrb; end
  end

  always @(negedge clk) begin
    if (if_done_o) ifd_n <= ifd_n + 1;
    if (mem_done_o) memd_n <= memd_n + 1;
  end

  task automatic run_txn(input vec_t v);
    int a0, aw0, w0, d0, cyc;
    logic got;
    a0 = ar_hs; aw0 = aw_hs; w0 = w_hs; d0 = v.is_mem ? memd_n : ifd_n; cyc = 0; got = 0;
    ar_dly = v.ar_dly; r_dly = v.r_dly; aw_dly = v.aw_dly; w_dly = v.w_dly;
    slv_rdata = v.rdata; slv_resp = v.resp;
    @(negedge clk);
    if (v.is_mem) begin
      mem_req = 1; mem_we = v.we; mem_addr = v.addr; mem_wdata = v.wdata; mem_sel = v.sel;
    end else begin
      if_req = 1; if_addr = v.addr;
    end
    while (!got && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
      got = v.is_mem ? mem_done_o : if_done_o;
      if (cyc == 1) check("stall_pending", v.is_mem ? mem_stall_req_o : if_stall_req_o, 1);
    end
    check("latency", cyc, v.lat);
    check("err", err_o, v.err);
    check("stall_at_done", v.is_mem ? mem_stall_req_o : if_stall_req_o, 0);
    check("other_done", v.is_mem ? if_done_o : mem_done_o, 0);
    if (!v.we) begin
      if (v.is_mem) exp_mem = v.rdata; else exp_if = v.rdata;
    end
    check("if_rdata", if_rdata_o, exp_if);
    check("mem_rdata", mem_rdata_o, exp_mem);
    @(negedge clk);
    mem_req = 0; if_req = 0; mem_we = 0;
    @(posedge clk); #1;
    check("done_pulse", {if_done_o, mem_done_o, err_o}, 0);
    check("done_count", (v.is_mem ? memd_n : ifd_n) - d0, 1);
    if (v.we) begin
      check("aw_count", aw_hs - aw0, 1);
      check("w_count", w_hs - w0, 1);
      check("ar_none", ar_hs - a0, 0);
      check("awaddr", cap_awaddr, v.addr);
      check("wdata", cap_wdata, v.wdata);
      check("wstrb", cap_wstrb, v.sel);
    end else begin
      check("ar_count", ar_hs - a0, 1);
      check("aw_none", aw_hs - aw0, 0);
      check("araddr", cap_araddr, v.addr);
    end
  endtask

  initial begin
    vec_t vecs[6];
    vec_t fv;
    int if_at, mem_at;
    vecs[0] = '{0, 0, 32'h0000_0100, 32'h0, 32'h2402_0001, 4'h0, 2'b00, 0, 0, 0, 0, 0, 3};
    vecs[1] = '{1, 0, 32'h8000_0010, 32'h0, 32'h1234_5678, 4'h0, 2'b10, 1, 0, 0, 0, 0, 3};
    vecs[2] = '{1, 1, 32'h8000_0004, 32'hDEAD_BEEF, 32'h0, 4'b0011, 2'b00, 0, 0, 0, 0, 2, 5};
    vecs[3] = '{0, 0, 32'h0000_0104, 32'h0, 32'h0042_0513, 4'h0, 2'b00, 0, 1, 0, 0, 0, 4};
    vecs[4] = '{1, 1, 32'h8000_0008, 32'h0102_0304, 32'h0, 4'b1100, 2'b10, 1, 0, 0, 2, 0, 5};
    vecs[5] = '{1, 0, 32'h0000_0040, 32'h0, 32'hCAFE_F00D, 4'h0, 2'b00, 0, 0, 1, 0, 0, 4};
    #1;
    check("rst_ctrl", {m_arvalid, m_rready, m_awvalid, m_wvalid, m_bready, if_done_o, mem_done_o, err_o}, 0);
    check("rst_rdata", {if_rdata_o, mem_rdata_o}, 0);
    check("rst_bus", {m_wstrb, m_wdata}, 0);
    check("rst_addr", {m_araddr, m_awaddr}, 0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 0;
    for (int i = 0; i < 6; i++) run_txn(vecs[i]);

    ar_dly = 0; r_dly = 0; slv_rdata = 32'h0BAD_0001; slv_resp = 0;
    if_at = 0; mem_at = 0;
    @(negedge clk);
    if_req = 1; if_addr = 32'h200; mem_req = 1; mem_we = 0; mem_addr = 32'h300;
    for (int c = 1; c <= 20 && (if_at == 0 || mem_at == 0); c++) begin
      @(posedge clk); #1;
      if (c == 1) check("both_stall", {if_stall_req_o, mem_stall_req_o}, 2'b11);
      if (if_done_o && if_at == 0) if_at = c;
      if (mem_done_o && mem_at == 0) mem_at = c;
      @(negedge clk);
      if (if_at != 0) if_req = 0;
      if (mem_at != 0) mem_req = 0;
    end
`ifdef MEM_ARB_RR_EN
    check("rr_if_first", if_at, 3);
    check("rr_mem_second", mem_at, 7);
`else
    check("prio_mem_first", mem_at, 3);
    check("prio_if_second", if_at, 7);
`endif
    exp_if = 32'h0BAD_0001; exp_mem = 32'h0BAD_0001;
    check("both_rdata", {if_rdata_o, mem_rdata_o}, {exp_if, exp_mem});

    r_dly = 1000;
    @(negedge clk);
    if_req = 1; if_addr = 32'h400;
    @(posedge clk);
    @(posedge clk); #1;
    check("rd_data_rready", {m_rready, m_arvalid}, 2'b10);
    #2 rst = 1;
    #1;
    check("rst_mid_ctrl", {m_arvalid, m_rready, m_awvalid, m_wvalid, m_bready, if_done_o, mem_done_o, err_o}, 0);
    check("rst_mid_rdata", {if_rdata_o, mem_rdata_o}, 0);
    check("rst_mid_stall", if_stall_req_o, 1);
    @(negedge clk);
    if_req = 0; r_dly = 0; exp_if = 0; exp_mem = 0;
    @(negedge clk) rst = 0;
    fv = '{0, 0, 32'h0000_0500, 32'h0, 32'hFEED_0005, 4'h0, 2'b00, 0, 0, 0, 0, 0, 3};
    run_txn(fv);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
